// File: rtl/rega_controller.sv
// Irrigation sequencing FSM: fills the tank, waters the soil, rests, and latches faults.
// Optional manual sessions are enabled with `define REGA_MANUAL_OVERRIDE_EN.
module rega_controller #(
  parameter int TIMER_W      = 16,
  parameter int WATER_CYCLES = 1000,
  parameter int FILL_TIMEOUT = 4000,
  parameter int REST_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic       soil_dry,
  input  logic       tank_empty,
  input  logic       tank_full,
  input  logic       fault_ack,
`ifdef REGA_MANUAL_OVERRIDE_EN
  input  logic       manual_req,
`endif
  output logic       pump_on,
  output logic       valve_on,
  output logic       alarm,
  output logic [2:0] state,
  output logic [7:0] sessions
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WATER = 3'd2,
    S_REST  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] WATER_LAST = TIMER_W'(WATER_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] REST_LAST  = TIMER_W'(REST_CYCLES - 1);

  state_t               state_q;
  state_t               next_state;
  logic [TIMER_W-1:0]   timer_q;
  logic [7:0]           sessions_q;
  logic                 conflict;
  logic                 active;
  logic                 run_ok;
  logic                 dry_ok;
  logic                 start;
  logic                 manual_start;
  logic                 manual_q;

  assign conflict = tank_empty & tank_full;
  assign active   = (state_q == S_FILL) | (state_q == S_WATER) | (state_q == S_REST);

`ifdef REGA_MANUAL_OVERRIDE_EN
  // A manual session keeps running regardless of enable and soil moisture.
  assign run_ok       = enable | manual_q;
  assign dry_ok       = soil_dry | manual_q;
  assign manual_start = manual_req;
`else
  assign run_ok       = enable;
  assign dry_ok       = soil_dry;
  assign manual_start = 1'b0;
`endif
  assign start = (enable & soil_dry) | manual_start;

  always_comb begin
    next_state = state_q;
    if (conflict) begin
      next_state = S_FAULT;
    end else if (active && !run_ok) begin
      next_state = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) next_state = tank_empty ? S_FILL : S_WATER;
        S_FILL: begin
          if (tank_full)                 next_state = S_WATER;
          else if (timer_q == FILL_LAST) next_state = S_FAULT;
        end
        S_WATER: begin
          if (tank_empty)                 next_state = S_FILL;
          else if (!dry_ok)               next_state = S_REST;
          else if (timer_q == WATER_LAST) next_state = S_REST;
        end
        S_REST:  if (timer_q == REST_LAST) next_state = S_IDLE;
        S_FAULT: if (fault_ack) next_state = S_IDLE;
        default: next_state = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      sessions_q <= '0;
      manual_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      // The timer restarts on every state entry, so it only measures the current stay.
      if (next_state != state_q) timer_q <= '0;
      else if (active)           timer_q <= timer_q + 1'b1;
      if (state_q == S_WATER && next_state == S_REST && sessions_q != 8'hFF)
        sessions_q <= sessions_q + 8'd1;
      if (next_state == S_IDLE)
        manual_q <= 1'b0;
      else if (state_q == S_IDLE && manual_start)
        manual_q <= 1'b1;
    end
  end

  assign pump_on  = (state_q == S_FILL);
  assign valve_on = (state_q == S_WATER);
  assign alarm    = (state_q == S_FAULT);
  assign state    = state_q;
  assign sessions = sessions_q;

endmodule

// File: tb/tb_rega_controller.sv
// Scoreboard bench for rega_controller: directed sequences push expected outputs, monitors compare.
module tb_rega_controller;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b0;
  logic       soil_dry = 1'b0;
  logic       tank_empty = 1'b0;
  logic       tank_full = 1'b0;
  logic       fault_ack = 1'b0;
  logic       pump_on;
  logic       valve_on;
  logic       alarm;
  logic [2:0] state;
  logic [7:0] sessions;
`ifdef REGA_MANUAL_OVERRIDE_EN
  logic       manual_req = 1'b0;
`endif

  rega_controller #(
    .TIMER_W(16), .WATER_CYCLES(8), .FILL_TIMEOUT(12), .REST_CYCLES(4)
  ) dut (
    .clk(clk), .clear(clear), .enable(enable), .soil_dry(soil_dry),
    .tank_empty(tank_empty), .tank_full(tank_full), .fault_ack(fault_ack),
`ifdef REGA_MANUAL_OVERRIDE_EN
    .manual_req(manual_req),
`endif
    .pump_on(pump_on), .valve_on(valve_on), .alarm(alarm),
    .state(state), .sessions(sessions)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [7:0] ses;
    string      nm;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       imm_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] ses_exp = 8'd0;
  event       chk_now;

  task automatic compare(input exp_t e);
    logic [13:0] act;
    logic [13:0] req;
    act = {state, pump_on, valve_on, alarm, sessions};
    req = {e.st, e.st == 3'd1, e.st == 3'd2, e.st == 3'd4, e.ses};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got state=%0d pump=%b valve=%b alarm=%b sessions=%0d, required state=%0d pump=%b valve=%b alarm=%b sessions=%0d",
               e.nm, state, pump_on, valve_on, alarm, sessions,
               e.st, req[10], req[9], req[8], e.ses);
    end
  endtask

  // Clocked monitor: one expected entry per edge, sampled 1ns after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) compare(sb_q.pop_front());
  end

  // Asynchronous monitor for checks that must hold with no clock edge.
  initial forever begin
    @(chk_now);
    if (imm_q.size() > 0) compare(imm_q.pop_front());
  end

  task automatic drv(input logic en, input logic dry, input logic te,
                     input logic tf, input logic ack);
    enable = en; soil_dry = dry; tank_empty = te; tank_full = tf; fault_ack = ack;
  endtask

  task automatic tick(input logic [2:0] st, input string nm);
    exp_t e;
    e.st = st; e.ses = ses_exp; e.nm = nm;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_now(input logic [2:0] st, input string nm);
    exp_t e;
    e.st = st; e.ses = ses_exp; e.nm = nm;
    imm_q.push_back(e);
    ->chk_now;
    #0;
  endtask

  initial begin
    @(negedge clk);
    check_now(3'd0, "reset_state");
    clear = 1'b0;

    // Normal session: 8 cycles WATER, 4 cycles REST, back to IDLE.
    drv(1, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick(3'd2, "normal_water");
    ses_exp = 8'd1;
    tick(3'd3, "normal_rest_entry");
    drv(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(3'd3, "normal_rest");
    tick(3'd0, "normal_idle");

    // Early stop: soil goes wet while the timer reads 3.
    drv(1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick(3'd2, "early_water");
    drv(1, 0, 0, 1, 0);
    ses_exp = 8'd2;
    tick(3'd3, "early_rest_entry");
    for (int i = 0; i < 3; i++) tick(3'd3, "early_rest");
    tick(3'd0, "early_idle");

    // Refill path: fill 5 cycles, water, tank runs empty mid-water.
    drv(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(3'd1, "refill_fill");
    drv(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(3'd2, "refill_water");
    drv(1, 1, 1, 0, 0);
    tick(3'd1, "refill_back_to_fill");
    tick(3'd1, "refill_fill_again");
    drv(0, 1, 1, 0, 0);
    tick(3'd0, "disable_to_idle");

    // Fill timeout: pump runs 12 cycles, then FAULT held until acknowledged.
    drv(1, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) tick(3'd1, "timeout_fill");
    tick(3'd4, "timeout_fault");
    drv(0, 1, 1, 0, 0);
    tick(3'd4, "fault_held_disabled");
    drv(0, 1, 1, 0, 1);
    tick(3'd0, "fault_ack_idle");

    // Conflict during REST.
    drv(1, 1, 0, 1, 0);
    tick(3'd2, "conflict_water");
    drv(1, 0, 0, 1, 0);
    ses_exp = 8'd3;
    tick(3'd3, "conflict_rest");
    drv(1, 0, 1, 1, 0);
    tick(3'd4, "conflict_fault");
    drv(1, 0, 1, 1, 1);
    tick(3'd4, "conflict_ack_held");
    tick(3'd4, "conflict_ack_held2");
    drv(1, 0, 0, 1, 0);
    tick(3'd4, "conflict_removed");
    drv(1, 0, 0, 1, 1);
    tick(3'd0, "conflict_ack_idle");

    // Conflict in IDLE blocks the start.
    drv(1, 1, 1, 1, 0);
    tick(3'd4, "idle_conflict_fault");
    drv(0, 1, 0, 1, 1);
    tick(3'd0, "idle_conflict_ack");

    // Asynchronous clear in the middle of WATER.
    drv(1, 1, 0, 1, 0);
    tick(3'd2, "midwater_a");
    tick(3'd2, "midwater_b");
    #2;
    clear = 1'b1;
    #1;
    ses_exp = 8'd0;
    check_now(3'd0, "clear_midwater_async");
    drv(0, 0, 0, 1, 0);
    #1;
    clear = 1'b0;
    @(negedge clk);
    tick(3'd0, "after_clear_idle");

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
